alu_rr_scheduler: RTL and testbench

//  Shares one combinational alu between N_REQ requesters (e.g. EX stage, branch-resolve unit).

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 77 +++++++
 rtl/alu_rr_scheduler.sv | 110 +++++++++++
 tb/tb_alu_rr_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and the legality check used by
// everything that issues work to the shared ALU.
package alu_pkg;

  typedef logic [5:0] alu_func_t;

  localparam alu_func_t ALU_FUNC_ADD  = 6'b100000;
  localparam alu_func_t ALU_FUNC_SUB  = 6'b100010;
  localparam alu_func_t ALU_FUNC_AND  = 6'b100100;
  localparam alu_func_t ALU_FUNC_SLT  = 6'b101000;
  localparam alu_func_t ALU_FUNC_SLTU = 6'b101001;
  localparam alu_func_t ALU_FUNC_BEQ  = 6'b111100;
  localparam alu_func_t ALU_FUNC_J    = 6'b111010;
  localparam alu_func_t ALU_FUNC_SLL  = 6'b000000;
  localparam alu_func_t ALU_FUNC_SRL  = 6'b000011;

  // Function codes the ALU implements; anything else is flagged as an error.
  function automatic logic alu_func_legal(input alu_func_t func);
    logic legal;
    casez (func)
      6'b1000??, 6'b1001??, 6'b101???, 6'b111???, 6'b000000, 6'b000011: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the
// pointer (wrapping), and moves the pointer past the winner when enabled.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW-1:0] ptr_r;
  logic [IW:0]   cand_s;
  logic [IW:0]   next_s;
  logic          found_s;

  // Scan from the pointer upward, modulo N, and keep the first active request.
  always_comb begin
    found_s = 1'b0;
    gnt_idx = '0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_r} + (IW+1)'(k);
      if (cand_s >= N_W) begin
        cand_s = cand_s - N_W;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        gnt_idx = cand_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant vector derived from the winning index.
  always_comb begin
    gnt = '0;
    if (found_s) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Pointer value that follows the current winner, wrapping at N.
  always_comb begin
    next_s = {1'b0, gnt_idx} + {{IW{1'b0}}, 1'b1};
    if (next_s == N_W) begin
      next_s = '0;
    end else begin
      next_s = next_s;
    end
  end

  // Advance the pointer only when a grant is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (en && found_s) begin
      ptr_r <= next_s[IW-1:0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between N_REQ requesters. Round-robin grant,
// operand mux to the ALU, and a one-entry registered response slot that can
// drain and refill in the same cycle. rsp_ready reaches req_ready
// combinationally; rsp_* come straight from registers.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*FUNC_W-1:0] req_func,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [FUNC_W-1:0]       alu_func,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_o,
  input  logic                    alu_branch,
  input  logic                    alu_jump,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_branch,
  output logic                    rsp_jump,
  output logic                    rsp_err
);

  logic             slot_free_s;
  logic             grant_s;
  logic             func_legal_s;
  logic [N_REQ-1:0] gnt_s;
  logic [ID_W-1:0]  gnt_idx_s;

  // The slot can accept a new op when empty or when it drains this cycle.
  assign slot_free_s = !rsp_valid || rsp_ready;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (slot_free_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // A grant is only real when the response slot has room for its result.
  always_comb begin
    if (slot_free_s) begin
      req_ready = gnt_s;
      grant_s   = |gnt_s;
    end else begin
      req_ready = '0;
      grant_s   = 1'b0;
    end
  end

  // Route the winner to the ALU; park it on ADD 0,0 when idle so it never sees X.
  always_comb begin
    alu_func = ALU_FUNC_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (grant_s) begin
      alu_func = req_func[gnt_idx_s*FUNC_W +: FUNC_W];
      alu_a    = req_a[gnt_idx_s*DATA_W +: DATA_W];
      alu_b    = req_b[gnt_idx_s*DATA_W +: DATA_W];
    end else begin
      alu_func = ALU_FUNC_ADD;
    end
  end

  assign func_legal_s = alu_func_legal(alu_func);

  // Response slot: capture on grant, clear valid on a bare drain, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_branch <= 1'b0;
      rsp_jump   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (grant_s) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx_s;
      if (func_legal_s) begin
        rsp_data   <= alu_o;
        rsp_branch <= alu_branch;
        rsp_jump   <= alu_jump;
        rsp_err    <= 1'b0;
      end else begin
        rsp_data   <= '0;
        rsp_branch <= 1'b0;
        rsp_jump   <= 1'b0;
        rsp_err    <= 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed, scoreboard-based bench for alu_rr_scheduler with a behavioural
// ALU stub and a small reference model of the grant pointer and slot.
module tb_alu_rr_scheduler;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int FW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*FW-1:0] req_func;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [FW-1:0]   alu_func;
  logic [DW-1:0]   alu_a, alu_b, alu_o;
  logic            alu_branch, alu_jump;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_branch, rsp_jump, rsp_err;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    logic        br;
    logic        jp;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   exp_ptr = 0;
  logic exp_full = 1'b0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N_REQ(N), .DATA_W(DW), .FUNC_W(FW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a), .req_b(req_b),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_branch(alu_branch), .alu_jump(alu_jump),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_branch(rsp_branch), .rsp_jump(rsp_jump),
    .rsp_err(rsp_err)
  );

  // Behavioural ALU: {jump, branch, data}. Unknown codes return a^b so an
  // illegal op that leaks through would be visible.
  function automatic logic [33:0] alu_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic br, jp;
    br = 1'b0; jp = 1'b0;
    case (f)
      6'b100000: d = a + b;
      6'b100010: d = a - b;
      6'b100100: d = a & b;
      6'b101000: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b101001: d = (a < b) ? 32'd1 : 32'd0;
      6'b111100: begin d = a; br = (a == b); end
      6'b111010: begin d = a; jp = 1'b1; end
      6'b000000: d = a << b[4:0];
      6'b000011: d = a >> b[4:0];
      default:   d = a ^ b;
    endcase
    return {jp, br, d};
  endfunction

  function automatic logic legal(input logic [5:0] f);
    casez (f)
      6'b1000??, 6'b1001??, 6'b101???, 6'b111???, 6'b000000, 6'b000011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    {alu_jump, alu_branch, alu_o} = alu_model(alu_func, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v;
    req_func[i*FW +: FW] = f;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  function automatic exp_t expect_for(input int i);
    exp_t e;
    logic [33:0] r;
    logic [5:0] f;
    f = req_func[i*FW +: FW];
    r = alu_model(f, req_a[i*DW +: DW], req_b[i*DW +: DW]);
    e.id = 1'(i);
    if (legal(f)) begin
      e.data = r[31:0]; e.br = r[32]; e.jp = r[33]; e.err = 1'b0;
    end else begin
      e.data = 32'd0; e.br = 1'b0; e.jp = 1'b0; e.err = 1'b1;
    end
    return e;
  endfunction

  // One clock: check outputs on the falling edge, then advance the model.
  task automatic cycle();
    logic [N-1:0] eg;
    logic grant;
    int gi, idx;
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(exp_full));
    if (exp_full && q.size() > 0) begin
      check("rsp_id",     64'(rsp_id),     64'(q[0].id));
      check("rsp_data",   64'(rsp_data),   64'(q[0].data));
      check("rsp_branch", 64'(rsp_branch), 64'(q[0].br));
      check("rsp_jump",   64'(rsp_jump),   64'(q[0].jp));
      check("rsp_err",    64'(rsp_err),    64'(q[0].err));
    end
    eg = '0; grant = 1'b0; gi = 0;
    if (!exp_full || rsp_ready) begin
      for (int k = 0; k < N; k++) begin
        idx = (exp_ptr + k) % N;
        if (!grant && req_valid[idx]) begin grant = 1'b1; gi = idx; end
      end
    end
    if (grant) eg[gi] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(eg));
    if (!grant) begin
      check("alu_idle_func", 64'(alu_func), 64'(6'b100000));
      check("alu_idle_ab",   {alu_a, alu_b}, 64'd0);
    end
    @(posedge clk);
    if (exp_full && rsp_ready && q.size() > 0) void'(q.pop_front());
    if (grant) begin
      q.push_back(expect_for(gi));
      exp_ptr = (gi + 1) % N;
      exp_full = 1'b1;
    end else if (rsp_ready) begin
      exp_full = 1'b0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_func = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp", {31'd0, rsp_id, rsp_data}, 64'd0);
    check("reset_flags", 64'({rsp_branch, rsp_jump, rsp_err}), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // 1: single ADD 5+7 from r0.
    set_req(0, 1'b1, 6'b100000, 32'd5, 32'd7);
    cycle();
    check("t1_id",   64'(rsp_id),   64'd0);
    check("t1_data", 64'(rsp_data), 64'd12);
    check("t1_err",  64'(rsp_err),  64'd0);
    set_req(0, 1'b0, 6'b100000, 32'd0, 32'd0);
    cycle();

    // 2: both requesters every cycle, ids alternate.
    set_req(0, 1'b1, 6'b100010, 32'd100, 32'd1);
    set_req(1, 1'b1, 6'b100100, 32'hffff0f0f, 32'h00000ff0);
    cycle(); check("t2_id_a", 64'(rsp_id), 64'd1);
    cycle(); check("t2_id_b", 64'(rsp_id), 64'd0);
    cycle(); check("t2_id_c", 64'(rsp_id), 64'd1);
    cycle(); check("t2_id_d", 64'(rsp_id), 64'd0);
    req_valid = '0;
    cycle();

    // 3: slot held full for three cycles, then drain and refill together.
    set_req(0, 1'b1, 6'b101000, 32'hfffffff0, 32'd3);
    cycle();
    set_req(0, 1'b0, 6'b101000, 32'd0, 32'd0);
    set_req(1, 1'b1, 6'b101001, 32'hfffffff0, 32'd3);
    rsp_ready = 1'b0;
    repeat (3) cycle();
    check("t3_frozen_data", 64'(rsp_data), 64'd1);
    rsp_ready = 1'b1;
    cycle();
    check("t3_refill_id", 64'(rsp_id), 64'd1);
    req_valid = '0;
    cycle();

    // 4: branch and jump flags from r1.
    set_req(1, 1'b1, 6'b111100, 32'h1234, 32'h1234);
    cycle();
    check("t4_beq", 64'({rsp_branch, rsp_jump, rsp_data}), {30'd0, 2'b10, 32'h1234});
    set_req(1, 1'b1, 6'b111010, 32'h40, 32'd0);
    cycle();
    check("t4_jump", 64'(rsp_jump), 64'd1);
    req_valid = '0;
    cycle();

    // 5: illegal codes, plus shifts sharing the slot.
    set_req(0, 1'b1, 6'b010101, 32'hdead, 32'hbeef);
    cycle();
    check("t5_err", 64'({rsp_err, rsp_branch, rsp_jump, rsp_data}), {29'd0, 3'b100, 32'd0});
    set_req(0, 1'b1, 6'b000000, 32'd1, 32'd4);
    set_req(1, 1'b1, 6'b000011, 32'h80, 32'd3);
    repeat (2) cycle();
    set_req(1, 1'b1, 6'b110000, 32'h5, 32'h6);
    req_valid[0] = 1'b0;
    cycle();
    req_valid = '0;
    cycle();

    // 6: async reset while a response is held; pointer returns to r0.
    set_req(0, 1'b1, 6'b100000, 32'd3, 32'd4);
    cycle();
    check("t6_pre_valid", 64'(rsp_valid), 64'd1);
    req_valid = '0;
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 64'(rsp_valid), 64'd0);
    check("t6_async_data", 64'(rsp_data), 64'd0);
    q.delete(); exp_ptr = 0; exp_full = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 6'b100000, 32'd10, 32'd20);
    set_req(1, 1'b1, 6'b100010, 32'd10, 32'd20);
    cycle();
    check("t6_tie_r0", 64'(rsp_id), 64'd0);
    req_valid = '0;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
